// File: rtl/alu_issue_stage.sv
// Operand-fetch / writeback stage around an external combinational ALU.
// Serialises one instruction at a time through IDLE -> EXEC -> WB over an 8-entry register file.
module alu_issue_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_op,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic [$clog2(NREG)-1:0] in_rs1,
  input  logic [$clog2(NREG)-1:0] in_rs2,
  input  logic [DW-1:0]           in_imm,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [4:0]              alu_f,
  input  logic [DW-1:0]           alu_s,
  output logic                    done,
  output logic                    err,
  output logic [DW-1:0]           result,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);

  localparam int AW = $clog2(NREG);
  localparam logic [4:0] OP_LDI = 5'd31;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf_q [NREG];
  logic [4:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   res_q;
  logic            ill_q;
  logic [DW-1:0]   alu_a_q, alu_b_q;
  logic [4:0]      alu_f_q;
  logic            done_q, err_q;
  logic [DW-1:0]   result_q;
  logic [DW-1:0]   rs1_val, rs2_val;
  logic            xfer;

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, and in_* are ignored otherwise.
  assign in_ready = (state_q == IDLE) && !rst;
  assign xfer     = in_valid && in_ready;

  // r0 reads as zero regardless of storage contents.
  assign rs1_val  = (in_rs1   == '0) ? '0 : rf_q[in_rs1];
  assign rs2_val  = (in_rs2   == '0) ? '0 : rf_q[in_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_f  = alu_f_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rf_q     <= '{default: '0};
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      ill_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_f_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            op_q    <= in_op;
            rd_q    <= in_rd;
            imm_q   <= in_imm;
            alu_a_q <= rs1_val;
            alu_b_q <= rs2_val;
            alu_f_q <= in_op;
          end
        end
        EXEC: begin
          res_q <= (op_q == OP_LDI) ? imm_q : alu_s;
          ill_q <= (op_q >= 5'd8) && (op_q <= 5'd30);
        end
        WB: begin
          // Register write and done land on the same edge, so dbg_data shows the new value with done.
          if (!ill_q && (rd_q != '0)) rf_q[rd_q] <= res_q;
          done_q   <= 1'b1;
          err_q    <= ill_q;
          result_q <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small ALU model and a done-driven scoreboard.
// ALU codes modelled here: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 pass A.
module tb_alu_issue_stage;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [2:0]    in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic [DW-1:0] alu_a, alu_b, alu_s;
  logic [4:0]    alu_f;
  logic          done, err;
  logic [DW-1:0] result;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  logic [DW:0] exp_q[$];
  int          acc_q[$];
  int          cyc;
  int          chk_cnt;
  int          pass_cnt;
  int          done_cnt;

  alu_issue_stage #(.DW(DW), .NREG(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_s    (alu_s),
    .done     (done),
    .err      (err),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always_comb begin
    case (alu_f)
      5'd0:    alu_s = alu_a + alu_b;
      5'd1:    alu_s = alu_a - alu_b;
      5'd2:    alu_s = alu_a & alu_b;
      5'd3:    alu_s = alu_a | alu_b;
      5'd4:    alu_s = alu_a ^ alu_b;
      5'd5:    alu_s = alu_a << 1;
      5'd6:    alu_s = alu_a >> 1;
      5'd7:    alu_s = alu_a;
      default: alu_s = 16'hBAD0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s", name);
  endtask

  // accept-edge recorder for latency checking
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) acc_q.delete();
    else if (in_valid && in_ready) acc_q.push_back(cyc + 1);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) fail("unexpected_done");
      else begin
        e = exp_q.pop_front();
        chk("done_err_result", {15'd0, err, result}, {15'd0, e});
      end
      if (acc_q.size() == 0) fail("done_without_accept");
      else chk("done_latency", cyc - acc_q.pop_front(), 2);
    end
  end

  // driver tasks
  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [DW-1:0] imm, input logic e_err,
                      input logic [DW-1:0] e_res, input bit push, output int waits);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({e_err, e_res});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send1(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [DW-1:0] imm, input logic e_err,
                       input logic [DW-1:0] e_res);
    int w;
    send(op, rd, rs1, rs2, imm, e_err, e_res, 1'b1, w);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("drain_timeout");
  endtask

  task automatic dbg_chk(input logic [2:0] addr, input logic [DW-1:0] exp);
    dbg_addr = addr;
    #1;
    chk($sformatf("dbg_r%0d", addr), dbg_data, exp);
  endtask

  initial begin
    int w;
    int d0;
    cyc = 0; chk_cnt = 0; pass_cnt = 0; done_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_result", result, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_f", alu_f, 0);
    for (int i = 0; i < 8; i++) dbg_chk(3'(i), 16'h0000);

    // LDI + ADD
    send1(5'd31, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b0, 16'h0005);
    send1(5'd31, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b0, 16'h0003);
    send1(5'd0,  3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0008);
    drain();
    dbg_chk(3'd3, 16'h0008);

    // SUB, XOR, AND
    send1(5'd31, 3'd1, 3'd0, 3'd0, 16'h000A, 1'b0, 16'h000A);
    send1(5'd31, 3'd2, 3'd0, 3'd0, 16'h0004, 1'b0, 16'h0004);
    send1(5'd1,  3'd4, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0006);
    send1(5'd31, 3'd1, 3'd0, 3'd0, 16'h00FF, 1'b0, 16'h00FF);
    send1(5'd31, 3'd2, 3'd0, 3'd0, 16'h0F0F, 1'b0, 16'h0F0F);
    send1(5'd4,  3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0FF0);
    send1(5'd2,  3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h000F);
    drain();
    dbg_chk(3'd4, 16'h0006);
    dbg_chk(3'd5, 16'h0FF0);
    dbg_chk(3'd6, 16'h000F);

    // r0 stays zero
    send1(5'd31, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b0, 16'h1234);
    drain();
    dbg_chk(3'd0, 16'h0000);
    chk("alu_f_hold_ldi", alu_f, 31);
    send1(5'd0, 3'd6, 3'd0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    drain();
    dbg_chk(3'd6, 16'h0000);

    // illegal opcode
    send1(5'd9, 3'd7, 3'd1, 3'd2, 16'h5555, 1'b1, 16'hBAD0);
    drain();
    dbg_chk(3'd7, 16'h0000);
    chk("alu_f_hold_ill", alu_f, 9);
    chk("alu_a_hold_ill", alu_a, 16'h00FF);
    chk("alu_b_hold_ill", alu_b, 16'h0F0F);

    // back-to-back with in_valid held high
    send(5'd31, 3'd1, 3'd0, 3'd0, 16'h8001, 1'b0, 16'h8001, 1'b1, w);
    send(5'd5,  3'd2, 3'd1, 3'd0, 16'h0000, 1'b0, 16'h0002, 1'b1, w);
    chk("b2b_ready_low_cycles_1", w, 2);
    send(5'd0,  3'd3, 3'd2, 3'd2, 16'h0000, 1'b0, 16'h0004, 1'b1, w);
    chk("b2b_ready_low_cycles_2", w, 2);
    in_valid = 1'b0;
    drain();
    dbg_chk(3'd1, 16'h8001);
    dbg_chk(3'd2, 16'h0002);
    dbg_chk(3'd3, 16'h0004);

    // reset during EXEC of ADD r3
    send(5'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, w);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("post_rst_no_done", done_cnt, d0);
    chk("post_rst_result", result, 0);
    for (int i = 0; i < 8; i++) dbg_chk(3'(i), 16'h0000);

    // operation after reset
    send1(5'd31, 3'd5, 3'd0, 3'd0, 16'h0007, 1'b0, 16'h0007);
    send1(5'd0,  3'd6, 3'd5, 3'd5, 16'h0000, 1'b0, 16'h000E);
    drain();
    dbg_chk(3'd6, 16'h000E);

    // final report
    if (exp_q.size() != 0) fail("exp_q_not_empty");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
